// File: rtl/matrix_transpose_sched.sv
// Job sequencer for the 5x5 transpose unit: loads a matrix one row at a time,
// captures the transposed or unmodified matrix, then drains it one row at a time.
module matrix_transpose_sched #(
  parameter int ELEM_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*ELEM_W-1:0]   in_row,
  output logic [25*ELEM_W-1:0]  tr_in,
  input  logic [25*ELEM_W-1:0]  tr_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5*ELEM_W-1:0]   out_row,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = 5 * ELEM_W;
  localparam int MW = 25 * ELEM_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [MW-1:0]   mat_q, mat_d;
  logic [MW-1:0]   res_q, res_d;
  logic            op_q, op_d;
  logic            done_q, done_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
          else       state_d = S_IDLE;
        end
        S_LOAD: begin
          if (in_valid && (cnt_q == 3'd4)) state_d = S_EXEC;
          else                             state_d = S_LOAD;
        end
        S_EXEC: begin
          state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready && (cnt_q == 3'd4)) state_d = S_IDLE;
          else                              state_d = S_DRAIN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      mat_q  <= {MW{1'b0}};
      res_q  <= {MW{1'b0}};
      op_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mat_q  <= mat_d;
      res_q  <= res_d;
      op_q   <= op_d;
      done_q <= done_d;
    end
  end

  // Datapath next values; an aborted cycle writes neither matrix register
  always_comb begin
    cnt_d  = cnt_q;
    mat_d  = mat_q;
    res_d  = res_q;
    op_d   = op_q;
    done_d = 1'b0;
    if (abort) begin
      cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d  = op;
            cnt_d = 3'd0;
          end else begin
            op_d  = op_q;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            mat_d[RW*int'(cnt_q) +: RW] = in_row;
            cnt_d = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_EXEC: begin
          // mat_q has been stable for a full cycle, so tr_out is settled here
          res_d = op_q ? tr_out : mat_q;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (cnt_q == 3'd4) begin
              cnt_d  = 3'd0;
              done_d = 1'b1;
            end else begin
              cnt_d  = cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          cnt_d = 3'd0;
        end
      endcase
    end
  end

  // Outputs decoded only from registered state, so no input-to-output path exists
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_DRAIN);
    busy      = (state_q != S_IDLE);
    out_last  = (state_q == S_DRAIN) && (cnt_q == 3'd4);
    if (state_q == S_DRAIN) begin
      out_row = res_q[RW*int'(cnt_q) +: RW];
    end else begin
      out_row = {RW{1'b0}};
    end
  end

  assign tr_in = mat_q;
  assign done  = done_q;

endmodule

// File: tb/tb_matrix_transpose_sched.sv
// Scoreboard bench for matrix_transpose_sched with a behavioural transpose unit.
module tb_matrix_transpose_sched;

  localparam int EW = 9;
  localparam int RW = 5 * EW;
  localparam int MW = 25 * EW;

  logic          clk = 1'b0;
  logic          rst_n, start, op, abort, in_valid, in_ready;
  logic          out_valid, out_ready, out_last, busy, done;
  logic [RW-1:0] in_row, out_row;
  logic [MW-1:0] tr_in, tr_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int t_start = 0;
  bit alt_ready = 1'b0;
  bit pend = 1'b0;

  logic [EW-1:0] elem [5][5];
  logic [RW:0]   exp_q [$];

  matrix_transpose_sched #(.ELEM_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .tr_in(tr_in), .tr_out(tr_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural transpose unit
  always_comb begin
    tr_out = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        tr_out[RW*r + EW*c +: EW] = tr_in[RW*c + EW*r +: EW];
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_row(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < 5; c++) v[EW*c +: EW] = elem[r][c];
    return v;
  endfunction

  task automatic fill(input int base);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        elem[r][c] = EW'(base + 10*r + c);
    elem[2][2] = 9'h1FF;
  endtask

  task automatic push_exp(input logic opv);
    logic [RW-1:0] row;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) row[EW*c +: EW] = opv ? elem[c][r] : elem[r][c];
      exp_q.push_back({(r == 4) ? 1'b1 : 1'b0, row});
    end
  endtask

  // Output monitor: done timing, row order/stability and last flag
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("done", done, pend);
        if (done) begin
          check_eq("busy_at_done", busy, 1'b0);
          done_cnt++;
          done_cyc = cyc;
        end
        pend = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 1'b1, 1'b0);
          end else begin
            check_eq("out_row", out_row, exp_q[0][RW-1:0]);
            check_eq("out_last", out_last, exp_q[0][RW]);
            if (out_ready && !abort) begin
              pend = exp_q[0][RW];
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // out_ready driver: continuous or alternating 1,0
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = alt_ready ? ~out_ready : 1'b1;
    end
  end

  task automatic load(input logic opv, input bit gaps, input int abort_at);
    bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int r = 0;
    int k = 0;
    int guard = 0;
    bit hs;
    if (abort_at < 0) push_exp(opv);
    @(posedge clk); #1;
    start = 1'b1; op = opv; t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (r < 5 && guard < 100) begin
      in_valid = gaps ? pat[k % 8] : 1'b1;
      in_row = pack_row(r);
      k++; guard++;
      if (r == abort_at) begin
        abort = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        return;
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) r++;
    end
    in_valid = 1'b0;
    if (guard >= 100) check_eq("load_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_job(input bit poke);
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start = poke && busy && (exp_q.size() > 1);
      op = 1'b0;
      if (!busy && exp_q.size() == 0) break;
    end
    start = 1'b0;
    if (i >= 300) check_eq("job_timeout", 1'b1, 1'b0);
    @(negedge clk); #1;
  endtask

  task automatic job_checks(input int d0, input bit timed);
    check_eq("done_count", done_cnt, d0 + 1);
    check_eq("queue_empty", exp_q.size(), 0);
    if (timed) check_eq("done_cycle", done_cyc - t_start, 12);
  endtask

  initial begin
    int d0;
    int i;
    logic [RW-1:0] old3;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; abort = 1'b0; in_valid = 1'b0; in_row = '0;
    #3;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_out_row", out_row, '0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_tr_in", tr_in, '0);
    #19 rst_n = 1'b1;

    // Transpose, nominal timing
    fill(0); d0 = done_cnt;
    load(1'b1, 1'b0, -1); wait_job(1'b0); job_checks(d0, 1'b1);

    // Copy, nominal timing
    d0 = done_cnt;
    load(1'b0, 1'b0, -1); wait_job(1'b0); job_checks(d0, 1'b1);

    // Backpressure on both sides plus start pokes while busy
    fill(100); alt_ready = 1'b1; d0 = done_cnt;
    load(1'b1, 1'b1, -1); wait_job(1'b1); job_checks(d0, 1'b0);
    alt_ready = 1'b0;

    // Abort after three rows; the row presented with abort is discarded
    old3 = pack_row(3); fill(200); d0 = done_cnt;
    load(1'b1, 1'b0, 3);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b0);
    check_eq("abort_row3_kept", tr_in[RW*3 +: RW], old3);
    check_eq("abort_row0_new", tr_in[0 +: RW], pack_row(0));
    repeat (3) @(posedge clk);
    #1 check_eq("abort_no_done", done_cnt, d0);
    fill(50); d0 = done_cnt;
    load(1'b1, 1'b0, -1); wait_job(1'b0); job_checks(d0, 1'b1);

    // Abort and start together in IDLE
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", busy, 1'b0);
    check_eq("abort_start_in_ready", in_ready, 1'b0);

    // Reset while draining row 2
    fill(7);
    load(1'b0, 1'b0, -1);
    for (i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid && exp_q.size() == 3) break;
    end
    check_eq("reach_row2", i < 50, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_tr_in", tr_in, '0);
    check_eq("mid_rst_out_row", out_row, '0);
    exp_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    fill(0); d0 = done_cnt;
    load(1'b1, 1'b0, -1); wait_job(1'b0); job_checks(d0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_transpose_sched.md
# matrix_transpose_sched

Sequencing controller for the coprocessor's combinational 5x5 transpose unit (9-bit elements, 225-bit row-major matrix bus). Accepts a matrix row by row over a valid/ready stream, holds it stable on the transpose unit's input, captures either the transposed or the unmodified matrix, then streams the result back row by row. It sits between the host-facing load/store path and the transpose datapath, one job at a time.

## Interface
- ELEM_W, 9, element width in bits; row width RW = 5*ELEM_W, matrix width MW = 25*ELEM_W; dimension fixed at 5
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request, sampled only in IDLE
- op  in  1  0 = copy, 1 = transpose; latched with start
- abort  in  1  synchronous job cancel, any state
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid & in_ready
- in_row  in  RW  input row; element c at bits [ELEM_W*c +: ELEM_W]
- tr_in  out  MW  to transpose unit; row r at bits [RW*r +: RW]
- tr_out  in  MW  from transpose unit, combinational function of tr_in
- out_valid  out  1  output row valid
- out_ready  in  1  output row consumed when out_valid & out_ready
- out_row  out  RW  output row, same packing as in_row
- out_last  out  1  high with row 4 of the output
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last output handshake

## Operation
- Registers: mat_reg (MW, drives tr_in directly), res_reg (MW), op_q, row counter cnt (3 bits, 0..4), FSM state.
- FSM states: IDLE, LOAD, EXEC, DRAIN.
- IDLE: start=1 -> latch op into op_q, cnt=0, go to LOAD. in_ready=0, out_valid=0.
- LOAD: in_ready=1. On each handshake, write in_row into mat_reg row cnt and increment cnt. The handshake at cnt=4 moves to EXEC with cnt=0.
- EXEC (exactly 1 cycle): res_reg <= op_q ? tr_out : mat_reg. Go to DRAIN.
- DRAIN: out_valid=1, out_row = res_reg row cnt, out_last = (cnt==4).
  - Each handshake increments cnt.
  - The handshake at cnt=4 returns to IDLE and sets done=1 for the next cycle.
- mat_reg is not cleared between jobs. tr_in stays stable from EXEC until the next LOAD write.
- abort=1: next state IDLE, cnt=0, out_valid=0, no done pulse. mat_reg and res_reg keep their contents. abort takes priority over start and over any handshake in the same cycle; a row presented with abort is discarded.
- start while busy: ignored. in_valid outside LOAD: ignored (in_ready=0). Data values are passed through unmodified; no arithmetic, no saturation.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state IDLE, cnt 0, mat_reg 0, res_reg 0, op_q 0, tr_in 0, in_ready 0, out_valid 0, out_row 0, out_last 0, busy 0, done 0.
- Reset mid-job: the job is lost and all outputs take their reset values immediately.
- Best case with in_valid=1 and out_ready=1 continuously, start at cycle 0:
  - LOAD handshakes at cycles 1–5.
  - EXEC at cycle 6.
  - out_valid at cycles 7–11, out_last at cycle 11.
  - done=1 and busy=0 at cycle 12.
  - start accepted again at cycle 12.
- Output stall (out_valid=1, out_ready=0): out_row and out_last hold stable and out_valid stays high.
- Input gaps (in_valid=0): cnt and mat_reg hold.
- All outputs are registered or decoded only from state/cnt. There is no combinational path from in_valid or out_ready to any output.
- tr_out is sampled only in EXEC, one full cycle after the last mat_reg write.

## Test plan
- Transpose: op=1, load element (r,c) = 10r+c, out_ready=1 → out row r element c = 10c+r (row 0 = 0,10,20,30,40); out_last only on row 4; done at cycle 12.
- Copy: op=0, same load → out rows identical to input rows; element (3,4)=34 stays at row 3 col 4; diagonal value 0x1FF passes unchanged in both ops.
- Backpressure: in_valid pattern 1,0,1,1,0,1,1,1 and out_ready alternating 1,0 → order preserved, out_row stable during every stall, exactly 5 output handshakes, one done.
- Abort mid-LOAD after 3 rows → busy=0 next cycle, no done, in_ready=0. A following transpose job with new data produces a fully correct result.
- Start asserted during DRAIN → ignored, no change in output sequence. Abort and start in the same IDLE cycle → remains IDLE.
- rst_n low mid-DRAIN at row 2 → out_valid, busy, done, tr_in at 0 immediately. After release, a full job completes with the nominal cycle-12 done.
